// File: rtl/tensor_core_result_reader.sv
// Drains one 4x4 byte matrix from a snapshot of the tensor core register file
// as a row-major valid/ready byte stream, ending with a done pulse and checksum.
module tensor_core_result_reader #(
    parameter int DIM        = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic         clock_in,
    input  logic         reset_in,
    input  logic         start_in,
    input  logic         select_in,
    input  logic [255:0] register_file_data_in,
    input  logic         byte_ready_in,
    output logic [7:0]   byte_out,
    output logic         byte_valid_out,
    output logic [1:0]   row_out,
    output logic [1:0]   col_out,
    output logic         last_out,
    output logic         busy_out,
    output logic         done_out,
    output logic [15:0]  checksum_out
);

    localparam int NUM_ELEMS = DIM * DIM;
    localparam int NUM_SLOTS = 2 * NUM_ELEMS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [255:0]    snap_q, snap_d;
    logic            sel_q, sel_d;
    logic [3:0]      k_q, k_d;
    logic [15:0]     acc_q, acc_d;
    logic [15:0]     checksum_q, checksum_d;

    // Slot {n, k} is element [n][k>>2][k&3]; matrix 0 occupies the upper half.
    logic [DATA_WIDTH-1:0] elem_w [NUM_SLOTS];
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_elem
            assign elem_w[gi] = snap_q[(NUM_SLOTS - 1 - gi) * DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [DATA_WIDTH-1:0] cur_byte;
    logic                  streaming;
    logic [15:0]           sum_next;

    assign cur_byte  = elem_w[{sel_q, k_q}];
    assign streaming = (state_q == STREAM);
    assign sum_next  = acc_q + 16'(cur_byte);

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            sel_q      <= 1'b0;
            k_q        <= '0;
            acc_q      <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            sel_q      <= sel_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        sel_d      = sel_q;
        k_d        = k_q;
        acc_d      = acc_q;
        checksum_d = checksum_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = STREAM;
                    snap_d  = register_file_data_in;
                    sel_d   = select_in;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            STREAM: begin
                if (byte_ready_in) begin
                    acc_d = sum_next;
                    k_d   = 4'(k_q + 4'd1);
                    if (k_q == 4'd15) begin
                        state_d    = DONE;
                        checksum_d = sum_next;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Element outputs are forced to zero whenever no element is being offered.
    always_comb begin
        byte_valid_out = streaming;
        byte_out       = streaming ? 8'(cur_byte) : 8'd0;
        row_out        = streaming ? k_q[3:2] : 2'd0;
        col_out        = streaming ? k_q[1:0] : 2'd0;
        last_out       = streaming && (k_q == 4'd15);
        busy_out       = (state_q != IDLE);
        done_out       = (state_q == DONE);
        checksum_out   = checksum_q;
    end

endmodule

// File: tb/tb_tensor_core_result_reader.sv
// Self-checking bench: directed and randomized drains compared against a
// reference model that extracts elements by their documented bit offsets.
module tb_tensor_core_result_reader;

    logic         clk;
    logic         reset_in;
    logic         start_in;
    logic         select_in;
    logic [255:0] register_file_data_in;
    logic         byte_ready_in;
    logic [7:0]   byte_out;
    logic         byte_valid_out;
    logic [1:0]   row_out;
    logic [1:0]   col_out;
    logic         last_out;
    logic         busy_out;
    logic         done_out;
    logic [15:0]  checksum_out;

    int checks   = 0;
    int failures = 0;

    tensor_core_result_reader #(.DIM(4), .DATA_WIDTH(8)) dut (
        .clock_in              (clk),
        .reset_in              (reset_in),
        .start_in              (start_in),
        .select_in             (select_in),
        .register_file_data_in (register_file_data_in),
        .byte_ready_in         (byte_ready_in),
        .byte_out              (byte_out),
        .byte_valid_out        (byte_valid_out),
        .row_out               (row_out),
        .col_out               (col_out),
        .last_out              (last_out),
        .busy_out              (busy_out),
        .done_out              (done_out),
        .checksum_out          (checksum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: element [n][i][j] lives at (((1-n)*4 + (3-i))*4 + (3-j))*8.
    function automatic int elem_off(input int n, input int i, input int j);
        return (((1 - n) * 4 + (3 - i)) * 4 + (3 - j)) * 8;
    endfunction

    function automatic logic [7:0] elem(input logic [255:0] d, input int n, input int i, input int j);
        return d[elem_off(n, i, j) +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // mode 0: always ready; 1: random ready; 2: alternate ready plus a 5-cycle stall at k=7
    // poke_k: at this k, zero the data input and pulse start (-1 disables)
    // abort_k: at this k, assert reset instead of continuing (-1 disables)
    task automatic drain(input string name, input logic [255:0] data, input logic sel,
                         input int mode, input int poke_k, input int abort_k,
                         output int cycles, output int final_sum);
        logic [7:0] exp_b [16];
        int k, sum, stall, cyc;
        logic rdy;
        bit poked;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                exp_b[i*4 + j] = elem(data, int'(sel), i, j);
        register_file_data_in = data;
        select_in = sel;
        start_in  = 1'b1;
        tick();
        start_in  = 1'b0;
        select_in = ~sel;
        k = 0; sum = 0; stall = 0; cyc = 1; poked = 0;
        while (k < 16) begin
            chk({name, "_valid"}, 32'(byte_valid_out), 32'd1);
            chk({name, "_byte"},  32'(byte_out), 32'(exp_b[k]));
            chk({name, "_row"},   32'(row_out), 32'(k / 4));
            chk({name, "_col"},   32'(col_out), 32'(k % 4));
            chk({name, "_last"},  32'(last_out), 32'(k == 15));
            chk({name, "_busy"},  32'(busy_out), 32'd1);
            chk({name, "_done"},  32'(done_out), 32'd0);
            $display("%s cyc=%0d k=%0d byte=%02h row=%0d col=%0d", name, cyc, k, byte_out, row_out, col_out);
            if (abort_k == k) begin
                reset_in = 1'b1;
                byte_ready_in = 1'b1;
                tick();
                reset_in = 1'b0;
                chk({name, "_abort_valid"}, 32'(byte_valid_out), 32'd0);
                chk({name, "_abort_sum"},   32'(checksum_out), 32'd0);
                chk({name, "_abort_done"},  32'(done_out), 32'd0);
                chk({name, "_abort_busy"},  32'(busy_out), 32'd0);
                chk({name, "_abort_byte"},  32'(byte_out), 32'd0);
                tick();
                chk({name, "_abort_done2"}, 32'(done_out), 32'd0);
                cycles = cyc; final_sum = 0;
                return;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (k == 7 && stall < 5) begin
                        rdy = 1'b0;
                        stall++;
                    end else begin
                        rdy = (cyc % 2 == 1);
                    end
                end
            endcase
            byte_ready_in = rdy;
            if (poke_k == k && !poked) begin
                register_file_data_in = '0;
                start_in = 1'b1;
                poked = 1;
            end
            tick();
            start_in = 1'b0;
            if (rdy) begin
                sum += int'(exp_b[k]);
                k++;
            end
            cyc++;
            if (cyc > 400) begin
                chk({name, "_timeout"}, 32'(k), 32'd16);
                cycles = cyc; final_sum = sum;
                return;
            end
        end
        byte_ready_in = $urandom_range(0, 1);
        start_in = 1'b1;
        chk({name, "_done_pulse"}, 32'(done_out), 32'd1);
        chk({name, "_done_valid"}, 32'(byte_valid_out), 32'd0);
        chk({name, "_done_busy"},  32'(busy_out), 32'd1);
        chk({name, "_checksum"},   32'(checksum_out), 32'(sum));
        $display("%s done cyc=%0d checksum=%0d", name, cyc, checksum_out);
        cycles = cyc;
        tick();
        start_in = 1'b0;
        chk({name, "_idle_busy"}, 32'(busy_out), 32'd0);
        chk({name, "_idle_done"}, 32'(done_out), 32'd0);
        chk({name, "_hold_sum"},  32'(checksum_out), 32'(sum));
        tick();
        chk({name, "_no_restart"}, 32'(busy_out), 32'd0);
        final_sum = sum;
    endtask

    initial begin
        logic [255:0] basic, ones, d;
        int cyc, s;

        reset_in = 1'b1;
        start_in = 1'b1;
        select_in = 1'b0;
        register_file_data_in = rand_data();
        byte_ready_in = 1'b1;
        tick();
        tick();
        chk("rst_byte",  32'(byte_out), 32'd0);
        chk("rst_valid", 32'(byte_valid_out), 32'd0);
        chk("rst_row",   32'(row_out), 32'd0);
        chk("rst_col",   32'(col_out), 32'd0);
        chk("rst_last",  32'(last_out), 32'd0);
        chk("rst_busy",  32'(busy_out), 32'd0);
        chk("rst_done",  32'(done_out), 32'd0);
        chk("rst_sum",   32'(checksum_out), 32'd0);
        reset_in = 1'b0;
        start_in = 1'b0;
        tick();
        chk("rst_no_stream", 32'(busy_out), 32'd0);
        $display("reset checked");

        basic = rand_data();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                basic[elem_off(0, i, j) +: 8] = 8'(16 * i + j);

        drain("basic", basic, 1'b0, 0, -1, -1, cyc, s);
        chk("basic_latency", 32'(cyc), 32'd17);
        chk("basic_sum_const", 32'(checksum_out), 32'd408);

        ones = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                ones[elem_off(1, i, j) +: 8] = 8'hFF;
        drain("sel1", ones, 1'b1, 0, -1, -1, cyc, s);
        chk("sel1_sum_const", 32'(checksum_out), 32'd4080);

        drain("bp", basic, 1'b0, 2, -1, -1, cyc, s);
        chk("bp_sum_const", 32'(checksum_out), 32'd408);

        drain("iso", basic, 1'b0, 0, 4, -1, cyc, s);
        chk("iso_sum_const", 32'(checksum_out), 32'd408);

        drain("abort", basic, 1'b0, 0, -1, 9, cyc, s);
        drain("restart", basic, 1'b0, 0, -1, -1, cyc, s);
        chk("restart_sum_const", 32'(checksum_out), 32'd408);

        for (int t = 0; t < 6; t++) begin
            d = rand_data();
            drain("rand", d, 1'($urandom_range(0, 1)), 1, ((t % 2) == 0) ? int'($urandom_range(0, 15)) : -1, -1, cyc, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tensor_core_result_reader.md
# tensor_core_result_reader

Drains one 4x4 byte matrix out of the tensor core register file as a byte stream with a valid/ready handshake. It is the read-side counterpart to the CPU's per-byte tensor core register writes (opcodes 0x06/0x07). On a start pulse it snapshots the full 256-bit register file, then emits 16 elements in row-major order with row/column tags. It finishes with a done pulse and an unsigned checksum, so a host or testbench can unload matrix-multiply results without any further CPU instructions.

## Interface
- DIM, 4, matrix dimension (fixed 4; row/col ports are 2 bits)
- DATA_WIDTH, 8, element width in bits
- clock_in  input  1  rising-edge clock
- reset_in  input  1  synchronous, active-high reset
- start_in  input  1  request a drain; sampled only in IDLE
- select_in  input  1  matrix to drain; 0 = matrix 0 (result slot, bits [255:128]), 1 = matrix 1 (bits [127:0])
- register_file_data_in  input  256  tensor core register file read data
- byte_ready_in  input  1  downstream ready
- byte_out  output  8  current element
- byte_valid_out  output  1  byte_out/row_out/col_out/last_out are valid
- row_out  output  2  row index i of current element
- col_out  output  2  column index j of current element
- last_out  output  1  high with element (3,3)
- busy_out  output  1  drain in progress
- done_out  output  1  one-cycle pulse after the final transfer
- checksum_out  output  16  unsigned sum of the 16 transferred bytes, zero-extended

## Operation
- Element [n][i][j] of the register file sits at bit offset (((1-n)*4 + (3-i))*4 + (3-j))*8, 8 bits wide. Element [0][0][0] is bits [255:248]; element [1][3][3] is bits [7:0].
- States: IDLE, STREAM, DONE.
- IDLE: when start_in=1 at a clock edge, capture register_file_data_in into a 256-bit snapshot, latch select_in, clear the element counter and checksum accumulator, and go to STREAM. Changes to register_file_data_in after the capture edge do not affect the stream.
- STREAM:
  - byte_valid_out=1.
  - byte_out = snapshot element [sel][k>>2][k&3], where k is the 4-bit counter (0..15); row_out=k[3:2], col_out=k[1:0], last_out=(k==15).
  - A transfer occurs on an edge with byte_valid_out && byte_ready_in. On a transfer, add byte_out to the accumulator and increment k.
  - A transfer at k==15 moves to DONE.
- DONE (exactly one cycle): byte_valid_out=0, done_out=1; checksum_out updates to the final sum. Next state IDLE.
- checksum_out holds its value until the next DONE or reset. The sum is at most 16*255 = 4080, so it never wraps in 16 bits.
- busy_out=1 in STREAM and DONE, 0 in IDLE.
- start_in is ignored in STREAM and DONE. No queuing: a start in the DONE cycle is lost.
- Output hold: while byte_valid_out=1 and byte_ready_in=0, byte_out, row_out, col_out and last_out stay stable. byte_valid_out never drops before the transfer completes.

## Timing
- Reset: on an edge with reset_in=1, state returns to IDLE and the counter clears. All outputs read 0 after that edge: byte_out, byte_valid_out, row_out, col_out, last_out, busy_out, done_out, checksum_out. Reset overrides start_in and any handshake on the same edge.
- Reset mid-stream: the stream aborts with no done_out, and checksum_out is cleared.
- Latency: start edge → byte_valid_out=1 in the next cycle with element (0,0).
- With byte_ready_in held at 1, one element transfers per cycle. The 16 transfers occupy cycles 1–16 after the start edge; done_out is high in cycle 17; busy_out falls in cycle 18.
- The earliest accepted restart is an edge in cycle 18, in IDLE.
- Downstream back-pressure of any length only stretches STREAM. Ordering and checksum are unchanged.
- byte_ready_in may be high while byte_valid_out=0; it has no effect.

## Test plan
- Reset: hold reset_in for 2 cycles with arbitrary inputs → every output is 0. With start_in=1 during reset, no stream starts.
- Basic drain: load the snapshot with element [0][i][j] = 16*i + j, select_in=0, byte_ready_in=1. Required: bytes 0x00,0x01,0x02,0x03,0x10,…,0x33 in cycles 1–16; row/col match i/j; last_out only on 0x33; done_out in cycle 17; checksum_out = 408 (0x198).
- Select matrix 1: element [1][i][j] = 0xFF for all i,j and matrix 0 = 0x00, select_in=1 → sixteen 0xFF bytes, checksum_out = 4080 (0x0FF0).
- Back-pressure: as the basic drain, with byte_ready_in low on alternate cycles and low for 5 cycles at k=7. Required: byte_out stays 0x13 with row=1, col=3 throughout the stall; same sequence and checksum; done_out pulses 1 cycle after the 16th handshake.
- Snapshot isolation and start-while-busy: change register_file_data_in to all-zero and pulse start_in at k=4 → stream and checksum unchanged, with no second stream.
- Reset mid-stream: assert reset_in at k=9 → byte_valid_out=0 and checksum_out=0 next cycle, with no done_out. A new start then streams from element (0,0).
